// File: rtl/ifetch_unit.sv
// Instruction fetch stage: owns the PC, requests words from instruction memory
// and holds one registered instruction for decode, with redirect and HLT handling.
module ifetch_unit #(
   parameter logic [15:0] RESET_PC = 16'h0000,
   parameter logic [3:0]  HLT_OP   = 4'hF
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [15:0] imem_addr,
   input  logic        imem_rdy,
   input  logic [15:0] imem_rdata,
   output logic [15:0] instr,
   output logic [15:0] instr_pc,
   output logic        instr_vld,
   input  logic        id_stall,
   input  logic        redirect,
   input  logic [15:0] redirect_pc,
   output logic        halted
);

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      HLT_PEND = 2'd1,
      HALTED   = 2'd2
   } state_t;

   state_t      state;
   state_t      state_nxt;
   logic [15:0] pc;
   logic [15:0] pc_nxt;
   logic [15:0] instr_nxt;
   logic [15:0] instr_pc_nxt;
   logic        vld_nxt;
   logic        halted_nxt;
   logic        xfer;
   logic        consume;
   logic        redir_ok;

   function automatic logic [15:0] pc_inc(input logic [15:0] p);
      return p + 16'd1;
   endfunction

   // rst gates the request so memory never sees a fetch while reset is held
   assign imem_req  = !rst && (state == RUN) && !redirect && (!instr_vld || !id_stall);
   assign imem_addr = pc;

   assign xfer     = imem_req && imem_rdy;
   assign consume  = instr_vld && !id_stall;
   assign redir_ok = redirect && (state != HALTED);

   always_comb begin
      state_nxt    = state;
      pc_nxt       = pc;
      instr_nxt    = instr;
      instr_pc_nxt = instr_pc;
      vld_nxt      = instr_vld;
      halted_nxt   = halted;
      if (redir_ok) begin
         // a HLT waiting in the output register is squashed along with any data
         vld_nxt   = 1'b0;
         pc_nxt    = redirect_pc;
         state_nxt = RUN;
      end else if (xfer) begin
         instr_nxt    = imem_rdata;
         instr_pc_nxt = pc;
         vld_nxt      = 1'b1;
         pc_nxt       = pc_inc(pc);
         if (imem_rdata[15:12] == HLT_OP) begin
            state_nxt = HLT_PEND;
         end
      end else if (consume) begin
         vld_nxt = 1'b0;
         if (state == HLT_PEND) begin
            halted_nxt = 1'b1;
            state_nxt  = HALTED;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= RUN;
         pc        <= RESET_PC;
         instr     <= 16'h0000;
         instr_pc  <= 16'h0000;
         instr_vld <= 1'b0;
         halted    <= 1'b0;
      end else begin
         state     <= state_nxt;
         pc        <= pc_nxt;
         instr     <= instr_nxt;
         instr_pc  <= instr_pc_nxt;
         instr_vld <= vld_nxt;
         halted    <= halted_nxt;
      end
   end

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed table-driven bench for ifetch_unit; memory returns addr+16'h1000
// unless a row forces a HLT word.
module tb_ifetch_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_req;
   logic [15:0] imem_addr;
   logic        imem_rdy;
   logic [15:0] imem_rdata;
   logic [15:0] instr;
   logic [15:0] instr_pc;
   logic        instr_vld;
   logic        id_stall;
   logic        redirect;
   logic [15:0] redirect_pc;
   logic        halted;
   logic        mem_hlt;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   assign imem_rdata = mem_hlt ? 16'hF000 : imem_addr + 16'h1000;

   ifetch_unit dut (
      .clk        (clk),
      .rst        (rst),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_rdy   (imem_rdy),
      .imem_rdata (imem_rdata),
      .instr      (instr),
      .instr_pc   (instr_pc),
      .instr_vld  (instr_vld),
      .id_stall   (id_stall),
      .redirect   (redirect),
      .redirect_pc(redirect_pc),
      .halted     (halted)
   );

   typedef struct {
      logic        rst;
      logic        rdy;
      logic        stall;
      logic        redir;
      logic [15:0] rpc;
      logic        hlt;
      logic        e_req;
      logic [15:0] e_addr;
      logic        e_vld;
      logic [15:0] e_instr;
      logic [15:0] e_ipc;
      logic        e_halt;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic r, input logic rdy, input logic st, input logic rd,
                      input logic [15:0] rpc, input logic h, input logic req,
                      input logic [15:0] addr, input logic vld, input logic [15:0] ins,
                      input logic [15:0] ipc, input logic hlt);
      vec_t v;
      v = '{r, rdy, st, rd, rpc, h, req, addr, vld, ins, ipc, hlt};
      vecs.push_back(v);
   endtask

   task automatic chk(input string name, input int row, input logic [15:0] act,
                      input logic [15:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
      end
   endtask

   task automatic chk_all(input int row, input logic req, input logic [15:0] addr,
                          input logic vld, input logic [15:0] ins, input logic [15:0] ipc,
                          input logic hlt);
      chk("imem_req", row, {15'd0, imem_req}, {15'd0, req});
      chk("imem_addr", row, imem_addr, addr);
      chk("instr_vld", row, {15'd0, instr_vld}, {15'd0, vld});
      chk("instr", row, instr, ins);
      chk("instr_pc", row, instr_pc, ipc);
      chk("halted", row, {15'd0, halted}, {15'd0, hlt});
   endtask

   initial begin
      //   rst rdy stl red rpc      hlt | req addr     vld instr    ipc      halt
      // streaming after reset
      add(0, 1, 0, 0, 16'h0000, 0,   1, 16'h0000, 0, 16'h0000, 16'h0000, 0);
      add(0, 1, 0, 0, 16'h0000, 0,   1, 16'h0001, 1, 16'h1000, 16'h0000, 0);
      // three wait states at addr 2
      add(0, 0, 0, 0, 16'h0000, 0,   1, 16'h0002, 1, 16'h1001, 16'h0001, 0);
      add(0, 0, 0, 0, 16'h0000, 0,   1, 16'h0002, 0, 16'h1001, 16'h0001, 0);
      add(0, 0, 0, 0, 16'h0000, 0,   1, 16'h0002, 0, 16'h1001, 16'h0001, 0);
      add(0, 1, 0, 0, 16'h0000, 0,   1, 16'h0002, 0, 16'h1001, 16'h0001, 0);
      add(0, 1, 0, 0, 16'h0000, 0,   1, 16'h0003, 1, 16'h1002, 16'h0002, 0);
      add(0, 1, 0, 0, 16'h0000, 0,   1, 16'h0004, 1, 16'h1003, 16'h0003, 0);
      add(0, 1, 0, 0, 16'h0000, 0,   1, 16'h0005, 1, 16'h1004, 16'h0004, 0);
      // decode stall on 16'h1005
      add(0, 1, 1, 0, 16'h0000, 0,   0, 16'h0006, 1, 16'h1005, 16'h0005, 0);
      add(0, 1, 1, 0, 16'h0000, 0,   0, 16'h0006, 1, 16'h1005, 16'h0005, 0);
      add(0, 1, 0, 0, 16'h0000, 0,   1, 16'h0006, 1, 16'h1005, 16'h0005, 0);
      // redirect to 0x40 while addr 7 would transfer
      add(0, 1, 0, 1, 16'h0040, 0,   0, 16'h0007, 1, 16'h1006, 16'h0006, 0);
      add(0, 1, 0, 0, 16'h0000, 0,   1, 16'h0040, 0, 16'h1006, 16'h0006, 0);
      // redirect to 3, HLT fetched there
      add(0, 1, 0, 1, 16'h0003, 0,   0, 16'h0041, 1, 16'h1040, 16'h0040, 0);
      add(0, 1, 0, 0, 16'h0000, 1,   1, 16'h0003, 0, 16'h1040, 16'h0040, 0);
      add(0, 1, 1, 0, 16'h0000, 0,   0, 16'h0004, 1, 16'hF000, 16'h0003, 0);
      add(0, 1, 1, 0, 16'h0000, 0,   0, 16'h0004, 1, 16'hF000, 16'h0003, 0);
      add(0, 1, 0, 0, 16'h0000, 0,   0, 16'h0004, 1, 16'hF000, 16'h0003, 0);
      // halted: redirect ignored
      add(0, 1, 0, 1, 16'h0020, 0,   0, 16'h0004, 0, 16'hF000, 16'h0003, 1);
      add(0, 1, 0, 0, 16'h0000, 0,   0, 16'h0004, 0, 16'hF000, 16'h0003, 1);
      // async reset out of HALTED
      add(1, 1, 0, 0, 16'h0000, 0,   0, 16'h0000, 0, 16'h0000, 16'h0000, 0);
      // HLT at 5 squashed by redirect to 0x20
      add(0, 1, 0, 1, 16'h0005, 0,   0, 16'h0000, 0, 16'h0000, 16'h0000, 0);
      add(0, 1, 0, 0, 16'h0000, 1,   1, 16'h0005, 0, 16'h0000, 16'h0000, 0);
      add(0, 1, 1, 0, 16'h0000, 0,   0, 16'h0006, 1, 16'hF000, 16'h0005, 0);
      add(0, 1, 1, 1, 16'h0020, 0,   0, 16'h0006, 1, 16'hF000, 16'h0005, 0);
      add(0, 1, 0, 0, 16'h0000, 0,   1, 16'h0020, 0, 16'hF000, 16'h0005, 0);
      // PC wrap via redirect to 0xFFFF
      add(0, 1, 0, 1, 16'hFFFF, 0,   0, 16'h0021, 1, 16'h1020, 16'h0020, 0);
      add(0, 1, 0, 0, 16'h0000, 0,   1, 16'hFFFF, 0, 16'h1020, 16'h0020, 0);
      add(0, 1, 0, 0, 16'h0000, 0,   1, 16'h0000, 1, 16'h0FFF, 16'hFFFF, 0);
      // reset asserted mid-stall
      add(0, 1, 1, 0, 16'h0000, 0,   0, 16'h0001, 1, 16'h1000, 16'h0000, 0);
      add(1, 1, 1, 0, 16'h0000, 0,   0, 16'h0000, 0, 16'h0000, 16'h0000, 0);
      add(0, 1, 0, 0, 16'h0000, 0,   1, 16'h0000, 0, 16'h0000, 16'h0000, 0);

      // reset state with memory ready
      rst         = 1'b1;
      imem_rdy    = 1'b1;
      id_stall    = 1'b0;
      redirect    = 1'b0;
      redirect_pc = 16'h0000;
      mem_hlt     = 1'b0;
      @(posedge clk);
      #1;
      chk_all(-1, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0);

      foreach (vecs[i]) begin
         rst         = vecs[i].rst;
         imem_rdy    = vecs[i].rdy;
         id_stall    = vecs[i].stall;
         redirect    = vecs[i].redir;
         redirect_pc = vecs[i].rpc;
         mem_hlt     = vecs[i].hlt;
         @(negedge clk);
         chk_all(i, vecs[i].e_req, vecs[i].e_addr, vecs[i].e_vld, vecs[i].e_instr,
                 vecs[i].e_ipc, vecs[i].e_halt);
         @(posedge clk);
         #1;
      end

      // after the last row: 16'h1000 is held; stall, then pulse reset between edges
      id_stall = 1'b1;
      imem_rdy = 1'b1;
      #1;
      chk_all(100, 1'b0, 16'h0001, 1'b1, 16'h1000, 16'h0000, 1'b0);
      #1;
      rst = 1'b1;
      #1;
      chk_all(101, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0);
      @(posedge clk);
      #1;
      rst      = 1'b0;
      id_stall = 1'b0;
      @(negedge clk);
      chk_all(102, 1'b1, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/ifetch_unit.md
Name: ifetch_unit

Overview:
- Instruction fetch stage for the 16-bit single-issue CPU; the producer end of the instruction word the decode stage consumes.
- Holds the PC and requests instruction words from instruction memory over a req/rdy handshake.
- Presents one registered instruction, with its PC, to decode under a valid/stall handshake.
- Handles branch redirect, and stops fetching once a HLT (opcode 4'hF) is fetched; enters a terminal halted state when decode accepts it.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset (word address).
- HLT_OP, 4'hF, opcode in instr[15:12] that halts fetch.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous reset, active-high.
- imem_req  output  1  fetch request valid.
- imem_addr  output  16  word address of requested instruction (current PC).
- imem_rdy  input  1  memory accepts the request; imem_rdata valid this cycle.
- imem_rdata  input  16  instruction word, sampled when imem_req && imem_rdy.
- instr  output  16  registered instruction to decode.
- instr_pc  output  16  PC of instr.
- instr_vld  output  1  instr holds a valid, unconsumed word.
- id_stall  input  1  decode cannot accept; consumption = instr_vld && !id_stall.
- redirect  input  1  branch/jump taken; flush and refetch.
- redirect_pc  input  16  new fetch address, sampled when redirect=1.
- halted  output  1  HLT consumed; fetch permanently stopped.

Behaviour:
- One clock (clk); reset asynchronous, active-high (rst).
- Reset values:
  - pc=RESET_PC, instr=16'h0000, instr_pc=16'h0000, instr_vld=0, halted=0, state=RUN.
  - imem_req=0 while rst is high.
- States:
  - RUN: normal fetch.
  - HLT_PEND: the output register holds a HLT; no requests.
  - HALTED: terminal; left only by reset.
- imem_req, combinational:
  - imem_req = (state==RUN) && !redirect && (!instr_vld || !id_stall).
  - imem_addr = pc, at all times.
- Transfer (imem_req && imem_rdy):
  - instr<=imem_rdata, instr_pc<=pc, instr_vld<=1, pc<=pc+1 (wraps 16'hFFFF -> 16'h0000).
  - If imem_rdata[15:12]==HLT_OP, state<=HLT_PEND.
- Memory wait states: while imem_req && !imem_rdy, pc, instr and instr_vld are unchanged; imem_req stays high unless id_stall rises with instr_vld=1 or redirect asserts. Memory must tolerate request withdrawal.
- Consumption without a new transfer: instr_vld<=0.
- Throughput: with imem_rdy=1 and id_stall=0 continuously, one instruction per cycle. Fetch-to-instr_vld latency is 1 cycle.
- Stall: instr_vld && id_stall holds instr, instr_pc and instr_vld stable and forces imem_req=0.
- Redirect (RUN or HLT_PEND), highest priority:
  - Next cycle: instr_vld=0, pc=redirect_pc, state=RUN.
  - Any same-cycle memory data is discarded; imem_req is 0 that cycle.
  - Fetch of redirect_pc begins the following cycle.
  - A HLT held in the output register is squashed.
- Redirect in HALTED is ignored.
- HLT_PEND:
  - No requests.
  - When the HLT is consumed (instr_vld && !id_stall): instr_vld<=0, halted<=1, state<=HALTED.
- HALTED: imem_req=0, instr_vld=0, halted=1 until rst.
- Reset mid-transfer: all state clears immediately and asynchronously; no partial update survives.
- Redirect and consumption in the same cycle: redirect wins; the consumed word is still delivered to decode that cycle (decode is responsible for squashing).

Test Plan:
- Reset, then streaming: rst pulse; imem_rdy=1, id_stall=0; memory returns instr=addr+16'h1000 -> imem_addr 0,1,2,3 on consecutive cycles; instr 16'h1000,16'h1001,... with instr_pc 0,1,2 one cycle later; instr_vld=1 continuously.
- Wait states and stall:
  - imem_rdy low 3 cycles at addr 2 -> imem_addr holds 2, instr_vld drops after instr 1 is consumed.
  - id_stall high 2 cycles with instr 16'h1005 valid -> imem_req=0, instr/instr_pc stable, no PC advance.
- Redirect: redirect=1, redirect_pc=16'h0040, while a transfer at addr 7 completes -> data for 7 discarded; next cycle instr_vld=0, imem_addr=16'h0040; following transfer yields instr_pc=16'h0040.
- HLT:
  - Fetch 16'hF000 at addr 3 -> no further imem_req.
  - Hold id_stall 2 cycles -> halted=0.
  - Release -> halted=1 next cycle; redirect then ignored; imem_req stays 0.
- HLT squash: HLT fetched at 5, redirect to 16'h0020 before consumption -> halted stays 0, fetch resumes at 16'h0020.
- PC wrap and async reset:
  - redirect_pc=16'hFFFF -> next address 16'h0000.
  - rst asserted mid-stall, between clock edges -> instr_vld, imem_req and halted fall immediately; pc=RESET_PC.
